// File: rtl/fetch_decode.sv
// Fetch/decode stage of the ToyProcessor: owns PC, MAR and IR and turns the
// one-hot timing steps S0..S5 into per-step datapath strobes.
module fetch_decode #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CLR,
    input  logic              S0,
    input  logic              S1,
    input  logic              S2,
    input  logic              S3,
    input  logic              S4,
    input  logic              S5,
    input  logic [DATA_W-1:0] MEM_DATA,
    output logic [ADDR_W-1:0] ADDR,
    output logic [ADDR_W-1:0] PC,
    output logic [DATA_W-1:0] IR,
    output logic              A_LD,
    output logic              B_LD,
    output logic              ALU_SUB,
    output logic              ALU_SEL,
    output logic              OUT_LD,
    output logic              HALT,
    output logic              SEQ_ERR
);

    localparam int unsigned OP_W   = DATA_W - ADDR_W;
    localparam int unsigned STEP_N = 6;

    localparam logic [OP_W-1:0] OP_LDA = OP_W'(0);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(2);
    localparam logic [OP_W-1:0] OP_OUT = OP_W'(14);
    localparam logic [OP_W-1:0] OP_HLT = OP_W'(15);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] mar_q;
    logic [DATA_W-1:0] ir_q;
    logic              halt_q;

    logic [STEP_N-1:0] steps;
    logic              one_hot;
    logic              active;
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] operand;
    logic              is_lda;
    logic              is_add;
    logic              is_sub;
    logic              is_out;
    logic              is_hlt;

    // Step legality: exactly one bit set (x & (x-1) clears the lowest set bit).
    assign steps   = {S5, S4, S3, S2, S1, S0};
    assign one_hot = (steps != '0) && ((steps & (steps - STEP_N'(1))) == '0);
    assign SEQ_ERR = ~one_hot;

    assign active  = one_hot & ~halt_q & ~RESET;

    assign op      = ir_q[DATA_W-1:ADDR_W];
    assign operand = ir_q[ADDR_W-1:0];
    assign is_lda  = (op == OP_LDA);
    assign is_add  = (op == OP_ADD);
    assign is_sub  = (op == OP_SUB);
    assign is_out  = (op == OP_OUT);
    assign is_hlt  = (op == OP_HLT);

    // Per-step datapath strobes; held for the whole step, consumed on its ending edge.
    always_comb begin
        A_LD    = 1'b0;
        B_LD    = 1'b0;
        ALU_SUB = 1'b0;
        ALU_SEL = 1'b0;
        OUT_LD  = 1'b0;
        if (active) begin
            if (S3 && is_out) begin
                OUT_LD = 1'b1;
            end
            if (S4) begin
                if (is_lda) begin
                    A_LD    = 1'b1;
                    ALU_SEL = 1'b0;
                end
                if (is_add || is_sub) begin
                    B_LD = 1'b1;
                end
            end
            if (S5 && (is_add || is_sub)) begin
                A_LD    = 1'b1;
                ALU_SEL = 1'b1;
                ALU_SUB = is_sub;
            end
        end
    end

    // Architectural registers; CLR wins over any step action, HALT freezes everything.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc_q   <= '0;
            mar_q  <= '0;
            ir_q   <= '0;
            halt_q <= 1'b0;
        end else if (CLR) begin
            pc_q   <= '0;
            mar_q  <= '0;
            ir_q   <= '0;
            halt_q <= 1'b0;
        end else if (one_hot && !halt_q) begin
            if (S0) begin
                mar_q <= pc_q;
            end
            if (S1) begin
                pc_q <= pc_q + ADDR_W'(1);
            end
            if (S2) begin
                ir_q <= MEM_DATA;
            end
            if (S3) begin
                if (is_lda || is_add || is_sub) begin
                    mar_q <= operand;
                end
                if (is_hlt) begin
                    halt_q <= 1'b1;
                end
            end
        end
    end

    assign ADDR = mar_q;
    assign PC   = pc_q;
    assign IR   = ir_q;
    assign HALT = halt_q;

endmodule
